// File: rtl/cpu_writeback_pkg.sv
// Shared micro-op codes, widths and helpers for the stack-machine writeback stage.
package cpu_writeback_pkg;

    localparam int DEF_STACK_DEPTH = 1024;
    localparam int DEF_KILL_CYCLES = 2;

    localparam int SP_W   = 11;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 35;

    typedef enum logic [2:0] {
        UC_PUSH_NONE  = 3'd0,
        UC_PUSH_ALU   = 3'd1,
        UC_PUSH_R0    = 3'd2,
        UC_PUSH_R1    = 3'd3,
        UC_PUSH_R1_R0 = 3'd4,
        UC_PUSH_R0_R1 = 3'd5,
        UC_PUSH_IMM   = 3'd6,
        UC_PUSH_PC    = 3'd7
    } push_code_t;

    typedef enum logic [1:0] {
        UC_BR_NONE   = 2'd0,
        UC_BR_ALWAYS = 2'd1,
        UC_BR_COND   = 2'd2,
        UC_BR_NCOND  = 2'd3
    } br_code_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PUSH2 = 1'b1
    } wb_state_t;

    function automatic logic is_double_push(input logic [2:0] code);
        return (code == UC_PUSH_R1_R0) || (code == UC_PUSH_R0_R1);
    endfunction

    // second selects the later value of a two-push pair; ignored for single pushes.
    function automatic logic [DATA_W-1:0] push_value(
        input logic [2:0]        code,
        input logic              second,
        input logic [31:0]       alu,
        input logic [DATA_W-1:0] r0,
        input logic [DATA_W-1:0] r1,
        input logic [31:0]       imm,
        input logic [31:0]       pc
    );
        logic [DATA_W-1:0] v;
        case (code)
            UC_PUSH_ALU:   v = {3'b000, alu};
            UC_PUSH_R0:    v = r0;
            UC_PUSH_R1:    v = r1;
            UC_PUSH_R1_R0: v = second ? r0 : r1;
            UC_PUSH_R0_R1: v = second ? r1 : r0;
            UC_PUSH_IMM:   v = {3'b000, imm};
            UC_PUSH_PC:    v = {3'b000, pc + 32'd6};
            default:       v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/cpu_writeback_branch_unit.sv
// Combinational branch resolution: decides whether the stage-3 branch is taken and where to.
module cpu_branch_unit
    import cpu_writeback_pkg::*;
(
    input  logic [1:0]  branch,
    input  logic        cond,
    input  logic [31:0] target_field,
    output logic        taken,
    output logic [31:0] target
);

    always_comb begin
        taken = 1'b0;
        case (branch)
            UC_BR_ALWAYS: taken = 1'b1;
            UC_BR_COND:   taken = cond;
            UC_BR_NCOND:  taken = ~cond;
            default:      taken = 1'b0;
        endcase
    end

    assign target = target_field;

endmodule

// File: rtl/cpu_writeback.sv
// Writeback stage of a stack CPU: pops/pushes the data stack, sequences two-value
// pushes over two cycles, and turns taken branches into a redirect plus squash window.
module cpu_writeback
    import cpu_writeback_pkg::*;
#(
    parameter int STACK_DEPTH = DEF_STACK_DEPTH,
    parameter int KILL_CYCLES = DEF_KILL_CYCLES
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               alu__cond_3a,
    input  logic [31:0]        alu__out_3a,
    input  logic [1:0]         c__branch_3a,
    input  logic [2:0]         c__to_push_3a,
    input  logic [47:0]        instruction_3a,
    input  logic [31:0]        pc_3a,
    input  logic [DATA_W-1:0]  r0_3a,
    input  logic [DATA_W-1:0]  r1_3a,
    input  logic [SP_W-1:0]    st__to_pop_3a,
    output logic               kill_4a,
    output logic               redirect_4a,
    output logic [31:0]        redirect_pc_4a,
    output logic               stall_4a,
    output logic               st_we,
    output logic [ADDR_W-1:0]  st_waddr,
    output logic [DATA_W-1:0]  st_wdata,
    output logic [SP_W-1:0]    st__sp_4a,
    output logic               st__ovf,
    output logic               st__unf
);

    localparam logic [SP_W-1:0] SP_MAX    = SP_W'(STACK_DEPTH);
    localparam logic [7:0]      KILL_LOAD = 8'(KILL_CYCLES);

    wb_state_t          state_reg, state_next;
    logic [SP_W-1:0]    sp_reg, sp_next;
    logic [7:0]         kill_cnt_reg, kill_cnt_next;
    logic               kill_reg, kill_next;
    logic               stall_reg, stall_next;
    logic               redirect_reg, redirect_next;
    logic [31:0]        redirect_pc_reg, redirect_pc_next;
    logic               we_reg, we_next;
    logic [ADDR_W-1:0]  waddr_reg, waddr_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;
    logic               ovf_reg, ovf_next;
    logic               unf_reg, unf_next;

    logic               accept;
    logic               taken;
    logic [31:0]        target;
    logic [SP_W-1:0]    sp_mid;
    logic               do_push;
    logic [DATA_W-1:0]  push_data;
    logic               unused_hi;

    // Only the low word of the instruction carries the target/immediate.
    assign unused_hi = ^instruction_3a[47:32];

    cpu_branch_unit u_branch (
        .branch       (c__branch_3a),
        .cond         (alu__cond_3a),
        .target_field (instruction_3a[31:0]),
        .taken        (taken),
        .target       (target)
    );

    // A new instruction is only consumed in IDLE outside the squash window.
    assign accept = (state_reg == ST_IDLE) && !kill_reg;

    always_comb begin
        state_next       = state_reg;
        sp_mid           = sp_reg;
        do_push          = 1'b0;
        push_data        = '0;
        stall_next       = 1'b0;
        redirect_next    = 1'b0;
        redirect_pc_next = redirect_pc_reg;
        ovf_next         = ovf_reg;
        unf_next         = unf_reg;
        we_next          = 1'b0;
        waddr_next       = waddr_reg;
        wdata_next       = wdata_reg;
        kill_cnt_next    = (kill_cnt_reg != 8'd0) ? kill_cnt_reg - 8'd1 : 8'd0;

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (st__to_pop_3a > sp_reg) begin
                        sp_mid   = '0;
                        unf_next = 1'b1;
                    end else begin
                        sp_mid = sp_reg - st__to_pop_3a;
                    end
                    if (c__to_push_3a != UC_PUSH_NONE) begin
                        do_push   = 1'b1;
                        push_data = push_value(c__to_push_3a, 1'b0, alu__out_3a,
                                               r0_3a, r1_3a, instruction_3a[31:0], pc_3a);
                    end
                    if (is_double_push(c__to_push_3a)) begin
                        state_next = ST_PUSH2;
                        stall_next = 1'b1;
                    end
                    if (taken) begin
                        redirect_next    = 1'b1;
                        redirect_pc_next = target;
                        kill_cnt_next    = KILL_LOAD;
                    end
                end
            end
            ST_PUSH2: begin
                // Inputs are held by the stall, so the same instruction supplies value two.
                do_push    = 1'b1;
                push_data  = push_value(c__to_push_3a, 1'b1, alu__out_3a,
                                        r0_3a, r1_3a, instruction_3a[31:0], pc_3a);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        sp_next = sp_mid;
        if (do_push) begin
            if (sp_mid >= SP_MAX) begin
                ovf_next = 1'b1;
            end else begin
                we_next    = 1'b1;
                waddr_next = sp_mid[ADDR_W-1:0];
                wdata_next = push_data;
                sp_next    = sp_mid + 1'b1;
            end
        end

        kill_next = (kill_cnt_next != 8'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            sp_reg          <= '0;
            kill_cnt_reg    <= '0;
            kill_reg        <= 1'b0;
            stall_reg       <= 1'b0;
            redirect_reg    <= 1'b0;
            redirect_pc_reg <= '0;
            we_reg          <= 1'b0;
            waddr_reg       <= '0;
            wdata_reg       <= '0;
            ovf_reg         <= 1'b0;
            unf_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sp_reg          <= sp_next;
            kill_cnt_reg    <= kill_cnt_next;
            kill_reg        <= kill_next;
            stall_reg       <= stall_next;
            redirect_reg    <= redirect_next;
            redirect_pc_reg <= redirect_pc_next;
            we_reg          <= we_next;
            waddr_reg       <= waddr_next;
            wdata_reg       <= wdata_next;
            ovf_reg         <= ovf_next;
            unf_reg         <= unf_next;
        end
    end

    assign kill_4a        = kill_reg;
    assign redirect_4a    = redirect_reg;
    assign redirect_pc_4a = redirect_pc_reg;
    assign stall_4a       = stall_reg;
    assign st_we          = we_reg;
    assign st_waddr       = waddr_reg;
    assign st_wdata       = wdata_reg;
    assign st__sp_4a      = sp_reg;
    assign st__ovf        = ovf_reg;
    assign st__unf        = unf_reg;

endmodule

// File: tb/tb_cpu_writeback.sv
// Bench for cpu_writeback: directed scenarios plus a randomized run against a sequence-level model.
module tb_cpu_writeback;

    localparam int DEPTH = 1024;
    localparam int KC    = 2;

    logic        clk, rst;
    logic        alu__cond_3a;
    logic [31:0] alu__out_3a;
    logic [1:0]  c__branch_3a;
    logic [2:0]  c__to_push_3a;
    logic [47:0] instruction_3a;
    logic [31:0] pc_3a;
    logic [34:0] r0_3a, r1_3a;
    logic [10:0] st__to_pop_3a;
    logic        kill_4a, redirect_4a, stall_4a, st_we, st__ovf, st__unf;
    logic [31:0] redirect_pc_4a;
    logic [9:0]  st_waddr;
    logic [34:0] st_wdata;
    logic [10:0] st__sp_4a;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [1:0]  br;
        logic        cond;
        logic [2:0]  push;
        logic [10:0] pop;
        logic [31:0] alu;
        logic [34:0] r0;
        logic [34:0] r1;
        logic [47:0] ins;
        logic [31:0] pc;
    } instr_t;

    cpu_writeback #(.STACK_DEPTH(DEPTH), .KILL_CYCLES(KC)) dut (
        .clk(clk), .rst(rst),
        .alu__cond_3a(alu__cond_3a), .alu__out_3a(alu__out_3a),
        .c__branch_3a(c__branch_3a), .c__to_push_3a(c__to_push_3a),
        .instruction_3a(instruction_3a), .pc_3a(pc_3a),
        .r0_3a(r0_3a), .r1_3a(r1_3a), .st__to_pop_3a(st__to_pop_3a),
        .kill_4a(kill_4a), .redirect_4a(redirect_4a), .redirect_pc_4a(redirect_pc_4a),
        .stall_4a(stall_4a), .st_we(st_we), .st_waddr(st_waddr), .st_wdata(st_wdata),
        .st__sp_4a(st__sp_4a), .st__ovf(st__ovf), .st__unf(st__unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t idle_instr();
        instr_t i;
        i.br = 2'd0; i.cond = 1'b0; i.push = 3'd0; i.pop = 11'd0; i.alu = 32'd0;
        i.r0 = 35'd0; i.r1 = 35'd0; i.ins = 48'd0; i.pc = 32'd0;
        return i;
    endfunction

    function automatic instr_t push_alu(input logic [31:0] v);
        instr_t i = idle_instr();
        i.push = 3'd1; i.alu = v;
        return i;
    endfunction

    function automatic logic [93:0] outs();
        return {st_we, st_waddr, st_wdata, st__sp_4a, st__ovf, st__unf,
                stall_4a, kill_4a, redirect_4a, redirect_pc_4a};
    endfunction

    task automatic drive(input instr_t i);
        c__branch_3a = i.br; alu__cond_3a = i.cond; c__to_push_3a = i.push;
        st__to_pop_3a = i.pop; alu__out_3a = i.alu; r0_3a = i.r0; r1_3a = i.r1;
        instruction_3a = i.ins; pc_3a = i.pc;
    endtask

    task automatic step(input instr_t i);
        @(negedge clk);
        drive(i);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(idle_instr());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [93:0] got;
        do_reset();
        step(push_alu(32'hABCD));
        got = outs();
        total++;
        if ({st_we, st__sp_4a} !== {1'b1, 11'd1})
            $display("FAIL reset_pre_push: got we/sp %b/%0d want 1/1", st_we, st__sp_4a);
        else passed++;
        #2 rst = 1'b1;
        #1 got = outs();
        total++;
        if (got !== 94'd0) $display("FAIL reset_async: got %h want 0", got);
        else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pop_push();
        instr_t i;
        logic [56:0] got;
        do_reset();
        for (int k = 0; k < 5; k++) step(push_alu(32'(k)));
        i = idle_instr();
        i.pop = 11'd2; i.push = 3'd1; i.alu = 32'h1234;
        step(i);
        got = {st_we, st_waddr, st_wdata, st__sp_4a};
        total++;
        if (got !== {1'b1, 10'd3, 35'h1234, 11'd4})
            $display("FAIL pop_push: got %h want %h", got, {1'b1, 10'd3, 35'h1234, 11'd4});
        else passed++;
        step(idle_instr());
        total++;
        if ({st_we, st__sp_4a} !== {1'b0, 11'd4})
            $display("FAIL pop_push_idle: got we/sp %b/%0d want 0/4", st_we, st__sp_4a);
        else passed++;
    endtask

    task automatic test_push2();
        instr_t i;
        logic [57:0] got;
        logic [34:0] a = 35'h5_1234_5678;
        logic [34:0] b = 35'h2_8765_4321;
        do_reset();
        for (int k = 0; k < 3; k++) step(push_alu(32'(k)));
        i = idle_instr();
        i.push = 3'd4; i.r0 = a; i.r1 = b;
        step(i);
        got = {st_we, st_waddr, st_wdata, st__sp_4a, stall_4a};
        total++;
        if (got !== {1'b1, 10'd3, b, 11'd4, 1'b1})
            $display("FAIL push2_first: got %h want %h", got, {1'b1, 10'd3, b, 11'd4, 1'b1});
        else passed++;
        @(posedge clk);
        #1;
        got = {st_we, st_waddr, st_wdata, st__sp_4a, stall_4a};
        total++;
        if (got !== {1'b1, 10'd4, a, 11'd5, 1'b0})
            $display("FAIL push2_second: got %h want %h", got, {1'b1, 10'd4, a, 11'd5, 1'b0});
        else passed++;
    endtask

    task automatic test_branch();
        instr_t i;
        logic [45:0] got;
        do_reset();
        i = idle_instr();
        i.br = 2'd2; i.cond = 1'b0; i.ins = 48'h200;
        step(i);
        total++;
        if ({redirect_4a, kill_4a} !== 2'b00)
            $display("FAIL branch_not_taken: got redirect/kill %b%b want 00", redirect_4a, kill_4a);
        else passed++;
        i.cond = 1'b1; i.ins = 48'h100;
        step(i);
        got = {redirect_4a, redirect_pc_4a, kill_4a, st_we, st__sp_4a};
        total++;
        if (got !== {1'b1, 32'h100, 1'b1, 1'b0, 11'd0})
            $display("FAIL branch_taken: got %h want %h", got, {1'b1, 32'h100, 1'b1, 1'b0, 11'd0});
        else passed++;
        for (int k = 0; k < 2; k++) begin
            step(push_alu(32'h77));
            got = {redirect_4a, redirect_pc_4a, kill_4a, st_we, st__sp_4a};
            total++;
            if (got !== {1'b0, 32'h100, (k == 0), 1'b0, 11'd0})
                $display("FAIL branch_kill_%0d: got %h want %h", k, got,
                         {1'b0, 32'h100, (k == 0), 1'b0, 11'd0});
            else passed++;
        end
        step(push_alu(32'h77));
        total++;
        if ({st_we, st__sp_4a, kill_4a} !== {1'b1, 11'd1, 1'b0})
            $display("FAIL branch_resume: got we/sp/kill %b/%0d/%b want 1/1/0", st_we, st__sp_4a, kill_4a);
        else passed++;
    endtask

    task automatic test_overflow();
        instr_t i;
        do_reset();
        for (int k = 0; k < DEPTH; k++) step(push_alu(32'(k)));
        total++;
        if ({st__sp_4a, st__ovf} !== {11'd1024, 1'b0})
            $display("FAIL ovf_fill: got sp/ovf %0d/%b want 1024/0", st__sp_4a, st__ovf);
        else passed++;
        step(push_alu(32'hDEAD));
        total++;
        if ({st_we, st__sp_4a, st__ovf} !== {1'b0, 11'd1024, 1'b1})
            $display("FAIL ovf_push: got we/sp/ovf %b/%0d/%b want 0/1024/1", st_we, st__sp_4a, st__ovf);
        else passed++;
        i = idle_instr();
        i.pop = 11'd1;
        step(i);
        total++;
        if ({st__sp_4a, st__ovf} !== {11'd1023, 1'b1})
            $display("FAIL ovf_sticky: got sp/ovf %0d/%b want 1023/1", st__sp_4a, st__ovf);
        else passed++;
    endtask

    task automatic test_underflow();
        instr_t i;
        do_reset();
        for (int k = 0; k < 2; k++) step(push_alu(32'(k)));
        i = idle_instr();
        i.pop = 11'd5;
        step(i);
        total++;
        if ({st__sp_4a, st__unf} !== {11'd0, 1'b1})
            $display("FAIL unf_pop: got sp/unf %0d/%b want 0/1", st__sp_4a, st__unf);
        else passed++;
        step(idle_instr());
        total++;
        if (st__unf !== 1'b1) $display("FAIL unf_sticky: got %b want 1", st__unf);
        else passed++;
    endtask

    task automatic test_reset_push2();
        instr_t i;
        logic [93:0] got;
        do_reset();
        for (int k = 0; k < 2; k++) step(push_alu(32'(k)));
        i = idle_instr();
        i.push = 3'd5; i.r0 = 35'h1_0000_0001; i.r1 = 35'h2_0000_0002;
        step(i);
        total++;
        if ({stall_4a, st_we, st_waddr} !== {1'b1, 1'b1, 10'd2})
            $display("FAIL rst_push2_enter: got stall/we/addr %b/%b/%0d want 1/1/2", stall_4a, st_we, st_waddr);
        else passed++;
        #2 rst = 1'b1;
        #1 got = outs();
        total++;
        if (got !== 94'd0) $display("FAIL rst_push2_async: got %h want 0", got);
        else passed++;
        @(negedge clk);
        drive(idle_instr());
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({st_we, stall_4a, st__sp_4a} !== 13'd0)
            $display("FAIL rst_push2_after: got we/stall/sp %b/%b/%0d want 0/0/0", st_we, stall_4a, st__sp_4a);
        else passed++;
    endtask

    // Sequence-level model state for the randomized run.
    int          m_sp, m_kill;
    logic        m_ovf, m_unf, m_we;
    logic [9:0]  m_waddr;
    logic [34:0] m_wdata;
    logic [31:0] m_rpc;

    task automatic model_push(input logic [34:0] v);
        if (m_sp == DEPTH) m_ovf = 1'b1;
        else begin
            m_we = 1'b1; m_waddr = 10'(m_sp); m_wdata = v; m_sp = m_sp + 1;
        end
    endtask

    task automatic test_back_to_back();
        instr_t i;
        logic [93:0] got, want;
        logic [34:0] v0, v1;
        int nv;
        logic taken;
        do_reset();
        m_sp = 0; m_kill = 0; m_ovf = 0; m_unf = 0; m_waddr = 0; m_wdata = 0; m_rpc = 0;
        for (int n = 0; n < 400; n++) begin
            i.br   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            i.cond = 1'($urandom_range(0, 1));
            i.push = 3'($urandom_range(0, 7));
            i.pop  = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(0, 2047)) : 11'($urandom_range(0, 2));
            i.alu  = $urandom;
            i.r0   = {3'($urandom_range(0, 7)), $urandom};
            i.r1   = {3'($urandom_range(0, 7)), $urandom};
            i.ins  = {16'($urandom), $urandom};
            i.pc   = $urandom;
            @(negedge clk);
            drive(i);
            m_we = 1'b0;
            nv = 0; taken = 1'b0; v0 = '0; v1 = '0;
            if (m_kill > 0) begin
                m_kill = m_kill - 1;
            end else begin
                if (int'(i.pop) > m_sp) begin m_sp = 0; m_unf = 1'b1; end
                else m_sp = m_sp - int'(i.pop);
                case (i.push)
                    3'd1: begin nv = 1; v0 = {3'b0, i.alu}; end
                    3'd2: begin nv = 1; v0 = i.r0; end
                    3'd3: begin nv = 1; v0 = i.r1; end
                    3'd4: begin nv = 2; v0 = i.r1; v1 = i.r0; end
                    3'd5: begin nv = 2; v0 = i.r0; v1 = i.r1; end
                    3'd6: begin nv = 1; v0 = {3'b0, i.ins[31:0]}; end
                    3'd7: begin nv = 1; v0 = {3'b0, i.pc + 32'd6}; end
                    default: nv = 0;
                endcase
                if (nv > 0) model_push(v0);
                taken = (i.br == 2'd1) || (i.br == 2'd2 && i.cond) || (i.br == 2'd3 && !i.cond);
                if (taken) begin m_kill = KC; m_rpc = i.ins[31:0]; end
            end
            @(posedge clk);
            #1;
            got  = outs();
            want = {m_we, m_waddr, m_wdata, 11'(m_sp), m_ovf, m_unf,
                    (nv == 2), (m_kill > 0), taken, m_rpc};
            total++;
            if (got !== want) $display("FAIL rand_%0d: got %h want %h", n, got, want);
            else passed++;
            if (nv == 2) begin
                m_we = 1'b0;
                if (m_kill > 0) m_kill = m_kill - 1;
                model_push(v1);
                @(posedge clk);
                #1;
                got  = outs();
                want = {m_we, m_waddr, m_wdata, 11'(m_sp), m_ovf, m_unf,
                        1'b0, (m_kill > 0), 1'b0, m_rpc};
                total++;
                if (got !== want) $display("FAIL rand_%0d_second: got %h want %h", n, got, want);
                else passed++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(idle_instr());
        test_reset();
        test_pop_push();
        test_push2();
        test_branch();
        test_overflow();
        test_underflow();
        test_reset_push2();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
